// File: rtl/tab_arbiter.sv
// Round-robin arbiter in front of a shared multiplication-table engine.
// Streams index/result pairs for the granted requester's 4-bit multiplier.
module tab_arbiter #(
  parameter int LEN = 11,
  parameter int IW  = 4,
  parameter int RW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [3:0]    mul0,
  input  logic          req1,
  input  logic [3:0]    mul1,
  input  logic          hold,
  output logic          gnt0,
  output logic          gnt1,
  output logic          busy,
  output logic          owner,
  output logic          out_valid,
  output logic [IW-1:0] index,
  output logic [RW-1:0] result,
  output logic          done0,
  output logic          done1
);

  localparam int PW = IW + 4;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [3:0]    mul_q, mul_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] index_q, index_d;
  logic [RW-1:0] result_q, result_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;

  logic          pick1;
  logic          last_entry;
  logic [PW-1:0] product;

  // On a tie, requester 1 wins only if requester 0 owned the previous table.
  assign pick1      = req1 & (~req0 | ~last_q);
  assign last_entry = (cnt_q == IW'(LEN - 1));
  assign product    = {4'b0000, cnt_q} * {{IW{1'b0}}, mul_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    owner_d  = owner_q;
    last_d   = last_q;
    busy_d   = busy_q;
    index_d  = index_q;
    result_d = result_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    valid_d  = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          owner_d = pick1;
          mul_d   = pick1 ? mul1 : mul0;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
        end
      end

      S_RUN: begin
        // A stalled consumer freezes the sequence; only the pulses drop.
        if (!hold) begin
          valid_d  = 1'b1;
          index_d  = cnt_q;
          result_d = RW'(product);
          cnt_d    = cnt_q + IW'(1);
          if (last_entry) begin
            done0_d = ~owner_q;
            done1_d = owner_q;
            busy_d  = 1'b0;
            last_d  = owner_q;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mul_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      index_q  <= '0;
      result_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mul_q    <= mul_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      index_q  <= index_d;
      result_q <= result_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign out_valid = valid_q;
  assign index     = index_q;
  assign result    = result_q;
  assign done0     = done0_q;
  assign done1     = done1_q;

endmodule

// File: tb/tb_tab_arbiter.sv
// Scoreboard bench for tab_arbiter: expected entries are queued per granted table
// and compared whenever out_valid is seen; a LEN=16 instance covers the maximum product.
module tb_tab_arbiter;
  localparam int LEN = 11;

  logic       clk = 1'b0;
  logic       rst, req0, req1, hold, req16;
  logic [3:0] mul0, mul1;
  logic       gnt0, gnt1, busy, owner, out_valid, done0, done1;
  logic [3:0] index;
  logic [7:0] result;
  logic       gnt0_16, gnt1_16, busy_16, owner_16, valid_16, done0_16, done1_16;
  logic [3:0] index_16;
  logic [7:0] result_16;

  int          tests = 0;
  int          fails = 0;
  logic [14:0] sb[$];
  logic [14:0] got, exp;

  always #5 clk = ~clk;

  tab_arbiter #(.LEN(LEN), .IW(4), .RW(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .mul0(mul0), .req1(req1), .mul1(mul1),
    .hold(hold), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .owner(owner),
    .out_valid(out_valid), .index(index), .result(result), .done0(done0), .done1(done1)
  );

  tab_arbiter #(.LEN(16), .IW(4), .RW(8)) dut16 (
    .clk(clk), .rst(rst), .req0(1'b0), .mul0(4'd0), .req1(req16), .mul1(mul1),
    .hold(1'b0), .gnt0(gnt0_16), .gnt1(gnt1_16), .busy(busy_16), .owner(owner_16),
    .out_valid(valid_16), .index(index_16), .result(result_16), .done0(done0_16),
    .done1(done1_16)
  );

  function automatic logic [14:0] pk(input logic o, input int i, input int r,
                                     input logic d0, input logic d1);
    logic [3:0] iv;
    logic [7:0] rv;
    iv = i[3:0];
    rv = r[7:0];
    return {o, iv, rv, d0, d1};
  endfunction

  task automatic push_table(input logic o, input int m);
    for (int i = 0; i < LEN; i++)
      sb.push_back(pk(o, i, i * m, (o == 1'b0) && (i == LEN - 1), (o == 1'b1) && (i == LEN - 1)));
  endtask

  task automatic test_reset;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; mul0 = 4'd0; mul1 = 4'd0; hold = 1'b0; req16 = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({gnt0, gnt1, busy, owner, out_valid, index, result, done0, done1} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp 0",
               {gnt0, gnt1, busy, owner, out_valid, index, result, done0, done1});
    end
    tests++;
    if ({gnt1_16, busy_16, valid_16, index_16, result_16, done1_16} !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs16 got %h exp 0",
               {gnt1_16, busy_16, valid_16, index_16, result_16, done1_16});
    end
    rst = 1'b1;
  endtask

  task automatic test_single;
    req0 = 1'b1; mul0 = 4'd3;
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, busy, owner, out_valid} !== 5'b10100) begin
      fails++;
      $display("FAIL single_grant got %b exp 10100", {gnt0, gnt1, busy, owner, out_valid});
    end
    req0 = 1'b0;
    push_table(1'b0, 3);
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp = sb.pop_front();
        got = {owner, index, result, done0, done1};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL single_entry got %h exp %h", got, exp);
        end
      end
    end
    tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_end got left=%0d busy=%b exp left=0 busy=0", sb.size(), busy);
    end
    @(negedge clk);
    tests++;
    if ({out_valid, done0, index, result} !== {2'b00, 4'd10, 8'd30}) begin
      fails++;
      $display("FAIL single_hold_last got %h exp %h", {out_valid, done0, index, result},
               {2'b00, 4'd10, 8'd30});
    end
  endtask

  task automatic test_both;
    int  gnt1_seen;
    logic prev_done0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; mul0 = 4'd2; mul1 = 4'd5;
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, owner} !== 3'b100) begin
      fails++;
      $display("FAIL both_first_grant got %b exp 100", {gnt0, gnt1, owner});
    end
    req0 = 1'b0;
    push_table(1'b0, 2);
    push_table(1'b1, 5);
    gnt1_seen = 0;
    prev_done0 = 1'b0;
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (prev_done0) begin
        tests++;
        if ({gnt1, out_valid, owner} !== 3'b101) begin
          fails++;
          $display("FAIL both_gap got %b exp 101", {gnt1, out_valid, owner});
        end
      end
      if (gnt1) begin
        gnt1_seen++;
        req1 = 1'b0;
      end
      prev_done0 = done0;
      if (out_valid) begin
        exp = sb.pop_front();
        got = {owner, index, result, done0, done1};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL both_entry got %h exp %h", got, exp);
        end
      end
    end
    tests++;
    if (sb.size() != 0 || gnt1_seen != 1) begin
      fails++;
      $display("FAIL both_end got left=%0d gnt1s=%0d exp left=0 gnt1s=1", sb.size(), gnt1_seen);
    end
  endtask

  task automatic test_round_robin;
    logic exp_next;
    int   grants, dones;
    req0 = 1'b1; req1 = 1'b1; mul0 = 4'd1; mul1 = 4'd4;
    exp_next = 1'b0;
    grants = 0;
    dones = 0;
    for (int c = 0; c < 100 && dones < 4; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        tests++;
        if ({gnt0, gnt1, owner} !== {~exp_next, exp_next, exp_next}) begin
          fails++;
          $display("FAIL rr_grant got %b exp %b", {gnt0, gnt1, owner},
                   {~exp_next, exp_next, exp_next});
        end
        push_table(exp_next, exp_next ? 4 : 1);
        exp_next = ~exp_next;
        grants++;
      end
      if (out_valid) begin
        got = {owner, index, result, done0, done1};
        exp = (sb.size() > 0) ? sb.pop_front() : 15'h7fff;
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL rr_entry got %h exp %h", got, exp);
        end
        if (done0 || done1) dones++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tests++;
    if (dones != 4 || grants != 4 || sb.size() != 0) begin
      fails++;
      $display("FAIL rr_end got dones=%0d grants=%0d left=%0d exp 4 4 0", dones, grants, sb.size());
    end
  endtask

  task automatic test_max_mul;
    int   v16;
    logic seen16;
    req1 = 1'b1; mul1 = 4'd15; req16 = 1'b1;
    push_table(1'b1, 15);
    v16 = 0;
    seen16 = 1'b0;
    for (int c = 0; c < 60 && (sb.size() > 0 || !seen16); c++) begin
      @(negedge clk);
      if (gnt1) req1 = 1'b0;
      if (gnt1_16) req16 = 1'b0;
      if (out_valid) begin
        got = {owner, index, result, done0, done1};
        exp = (sb.size() > 0) ? sb.pop_front() : 15'h7fff;
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL maxmul_entry got %h exp %h", got, exp);
        end
      end
      if (valid_16) v16++;
      if (done1_16) begin
        seen16 = 1'b1;
        tests++;
        if ({index_16, result_16, owner_16} !== {4'd15, 8'd225, 1'b1}) begin
          fails++;
          $display("FAIL maxmul16_last got %h exp %h", {index_16, result_16, owner_16},
                   {4'd15, 8'd225, 1'b1});
        end
      end
    end
    tests++;
    if (!seen16 || v16 != 16 || sb.size() != 0) begin
      fails++;
      $display("FAIL maxmul_end got seen16=%b valid16=%0d left=%0d exp 1 16 0", seen16, v16, sb.size());
    end
  endtask

  task automatic test_hold;
    int   nvalid;
    logic held;
    req0 = 1'b1; mul0 = 4'd7;
    @(negedge clk);
    tests++;
    if ({gnt0, owner} !== 2'b10) begin
      fails++;
      $display("FAIL hold_grant got %b exp 10", {gnt0, owner});
    end
    req0 = 1'b0;
    push_table(1'b0, 7);
    nvalid = 0;
    held = 1'b0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        exp = sb.pop_front();
        got = {owner, index, result, done0, done1};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL hold_entry got %h exp %h", got, exp);
        end
        if (index == 4'd4 && !held) begin
          held = 1'b1;
          hold = 1'b1;
          for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, done0, index, result} !== {2'b00, 4'd4, 8'd28}) begin
              fails++;
              $display("FAIL hold_freeze got %h exp %h", {out_valid, done0, index, result},
                       {2'b00, 4'd4, 8'd28});
            end
          end
          hold = 1'b0;
        end
      end
    end
    tests++;
    if (nvalid != LEN || sb.size() != 0 || !held) begin
      fails++;
      $display("FAIL hold_count got valid=%0d left=%0d exp valid=%0d left=0", nvalid, sb.size(), LEN);
    end
  endtask

  task automatic test_reset_mid;
    logic aborted;
    req0 = 1'b1; mul0 = 4'd9;
    @(negedge clk);
    tests++;
    if ({gnt0, owner} !== 2'b10) begin
      fails++;
      $display("FAIL rmid_grant got %b exp 10", {gnt0, owner});
    end
    req0 = 1'b0; req1 = 1'b1; mul1 = 4'd6;
    push_table(1'b0, 9);
    aborted = 1'b0;
    for (int c = 0; c < 30 && !aborted; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp = sb.pop_front();
        got = {owner, index, result, done0, done1};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL rmid_entry got %h exp %h", got, exp);
        end
        if (index == 4'd6) begin
          rst = 1'b0;
          aborted = 1'b1;
        end
      end
    end
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, busy, owner, out_valid, index, result, done0, done1} !== 19'd0) begin
      fails++;
      $display("FAIL rmid_cleared got %h exp 0",
               {gnt0, gnt1, busy, owner, out_valid, index, result, done0, done1});
    end
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    tests++;
    if ({gnt1, gnt0, owner, busy, out_valid} !== 5'b10110) begin
      fails++;
      $display("FAIL rmid_regrant got %b exp 10110", {gnt1, gnt0, owner, busy, out_valid});
    end
    req1 = 1'b0;
    push_table(1'b1, 6);
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp = sb.pop_front();
        got = {owner, index, result, done0, done1};
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL rmid_entry2 got %h exp %h", got, exp);
        end
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL rmid_end got left=%0d exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_round_robin();
    test_max_mul();
    test_hold();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tab_arbiter.md
Name: tab_arbiter

Overview:
- Controller that shares one multiplication-table engine between two requesters.
- Each requester asks for a table of its own 4-bit multiplier.
- The block arbitrates round-robin, sequences the counter/multiply datapath, and streams index/result pairs tagged with the owner.
- Sits between requesting control logic and the downstream table consumer.

Parameters:
- LEN, 11, entries per table; indices 0..LEN-1; legal range 2..16.
- IW, 4, index width (must hold LEN-1).
- RW, 8, result width (must hold 15*15=225).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- req0  in  1  requester 0 table request; held high until gnt0.
- mul0  in  4  requester 0 multiplier; sampled on grant.
- req1  in  1  requester 1 table request; held high until gnt1.
- mul1  in  4  requester 1 multiplier; sampled on grant.
- hold  in  1  consumer stall; freezes sequencing while in RUN.
- gnt0  out  1  one-cycle pulse: requester 0 accepted.
- gnt1  out  1  one-cycle pulse: requester 1 accepted.
- busy  out  1  high while a table is in progress (state RUN).
- owner  out  1  requester whose table is on the output (0/1).
- out_valid  out  1  index/result valid this cycle.
- index  out  IW  current table index.
- result  out  RW  index*multiplier.
- done0  out  1  pulse with the last entry of requester 0's table.
- done1  out  1  pulse with the last entry of requester 1's table.

Behaviour:
- All outputs are registered. Reset (rst==0 at a clk edge) forces:
  - state=IDLE;
  - gnt0/gnt1/busy/out_valid/done0/done1=0;
  - owner=0, index=0, result=0, cnt=0, mul_r=0;
  - rr pointer set so requester 0 wins the first tie.
  - Reset mid-table aborts it with no done pulse.
- FSM has two states, IDLE and RUN.
- IDLE:
  - No request: outputs idle (out_valid=0, done=0, gnt=0).
  - Only reqX=1: gntX=1, owner=X, mul_r=mulX, cnt=0, busy=1, go to RUN.
  - Both high: grant the requester that did not own the previous table (round-robin); after reset, requester 0.
- RUN, hold=0, at each edge:
  - out_valid=1, index=cnt, result=cnt*mul_r (zero-extended; no overflow possible), cnt=cnt+1, gnt=0.
- RUN, cnt==LEN-1 at the edge:
  - emit the last entry as above and assert done<owner>=1 in the same cycle;
  - set busy=0, go to IDLE, record owner as last served.
- RUN, hold=1 at the edge:
  - out_valid=0; index/result/cnt/done retain values, except done is forced 0.
  - No advance; hold in IDLE has no effect.
- Latency:
  - Grant is visible 1 cycle after the edge that samples the request.
  - First entry (index 0) is visible the cycle after the grant.
  - LEN valid cycles (plus hold cycles) follow.
- Back-to-back: the first IDLE edge after done may grant again. One cycle of out_valid=0 carries the new gnt pulse, so there is always at least one non-valid cycle between tables.
- Requests asserted during RUN are not sampled until IDLE.
- mulX changes after grant do not affect the table in progress.
- owner remains stable from grant until the next grant.
- index/result hold the last entry after done until the next table's first entry.
- cnt wraps are impossible (RUN exits at LEN-1); with LEN=16, cnt never exceeds 15.

Test Plan:
1. Reset, then req0=1, mul0=3 -> gnt0 pulse, then 11 valid cycles with index 0..10 and result 0,3,...,30; done0 with index=10/result=30; busy drops.
2. req0 and req1 both high (mul0=2, mul1=5) from reset -> requester 0 served first (results 0..20); one gap cycle with gnt1; then requester 1 served (0,5,...,50, done1); owner toggles accordingly.
3. Both requests held continuously -> grants alternate 0,1,0,1 across 4 tables; no requester is granted twice in a row.
4. mul1=15 (req1 only) -> final result=150 at index 10; with LEN=16 build, final result=225 at index 15, and no RW overflow.
5. hold=1 for 3 cycles at index 4 (mul0=7) -> out_valid=0 for 3 cycles, index stays 4 and result stays 28; resumes at index 5 result 35; total valid count still 11.
6. rst=0 for one cycle at index 6 -> next cycle all outputs 0, no done pulse; a pending req1 is then granted from IDLE with index restarting at 0.
